countdown_expiry_alarm: RTL and testbench

- Parametrised successor to the timer's all-LED expiry indicator.
- Watches an N-digit BCD countdown value and, once armed, detects expiry (all digits zero).
- On expiry it asserts a latched stop to the counter and drives a blinking, then steady, pattern on the LED bank until acknowledged.
- Sits between the BCD down-counter chain and the board LED outputs.

---
 rtl/timer_pkg.sv | 29 ++
 rtl/countdown_expiry_alarm_if.sv | 33 +++
 rtl/tick_phase_gen.sv | 58 +++++
 rtl/countdown_expiry_alarm.sv | 137 +++++++++++++
 tb/tb_countdown_expiry_alarm.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//   Shared types and constants for the countdown timer blocks.
//   - state_t     : expiry-alarm FSM state encoding (2 bits)
//   - BCD_W       : width of one BCD digit
//   - led_fill()  : helper that builds an all-on / all-off LED word
//   - LED_ALL_ON / LED_ALL_OFF : widest LED patterns. Users slice them down
//                                to their own LED_WIDTH (max LED_MAX_W).
// ---------------------------------------------------------------------------
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_ALARM  = 2'd2,
      ST_STEADY = 2'd3
   } state_t;

   localparam int BCD_W     = 4;
   localparam int LED_MAX_W = 64;

   function automatic logic [LED_MAX_W-1:0] led_fill(input logic on);
      return {LED_MAX_W{on}};
   endfunction

   localparam logic [LED_MAX_W-1:0] LED_ALL_ON  = led_fill(1'b1);
   localparam logic [LED_MAX_W-1:0] LED_ALL_OFF = led_fill(1'b0);

endpackage : timer_pkg

// File: rtl/countdown_expiry_alarm_if.sv
// ---------------------------------------------------------------------------
// countdown_expiry_alarm_if
//   Bundles the signals between the BCD down-counter / user-input side and
//   the expiry alarm.
//   master : counter side. Drives tick, run_en, digits and ack. Receives
//            stop, all_leds and alarm_active.
//   slave  : the alarm block (countdown_expiry_alarm).
// ---------------------------------------------------------------------------
interface countdown_expiry_alarm_if #(
   parameter int NUM_DIGITS = 2,
   parameter int LED_WIDTH  = 12
);
   import timer_pkg::*;

   logic                          tick;
   logic                          run_en;
   logic [BCD_W*NUM_DIGITS-1:0]   digits;
   logic                          ack;
   logic                          stop;
   logic [LED_WIDTH-1:0]          all_leds;
   logic                          alarm_active;

   modport master (
      output tick, run_en, digits, ack,
      input  stop, all_leds, alarm_active
   );

   modport slave (
      input  tick, run_en, digits, ack,
      output stop, all_leds, alarm_active
   );

endinterface : countdown_expiry_alarm_if

// File: rtl/tick_phase_gen.sv
// ---------------------------------------------------------------------------
// tick_phase_gen
//   Blink phase generator. It counts i_tick pulses while i_enable is high.
//   Every DIV ticks it inverts o_phase. While i_clear is high, the counter
//   is held at 0 and the phase is held at 1, so a fresh blink sequence always
//   starts in the "on" half.
//   Ports:
//     clk       in   clock
//     reset     in   synchronous active-high reset
//     i_clear   in   hold counter at 0, phase at 1
//     i_tick    in   one-clk time-base pulse
//     i_enable  in   allow ticks to advance the counter
//     o_phase   out  current phase (registered)
//     o_toggle  out  high when o_phase inverts on the coming edge. Consumers
//                    that register a phase-dependent value use it so that
//                    their register stays cycle-aligned with o_phase.
// ---------------------------------------------------------------------------
module tick_phase_gen #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_tick,
   input  logic i_enable,
   output logic o_phase,
   output logic o_toggle
);

   localparam int            CW   = $clog2(DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_phase;
   logic          w_adv;
   logic          w_wrap;

   assign w_adv  = i_enable && i_tick && !i_clear;
   assign w_wrap = w_adv && (r_cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples its inputs from before the edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_cnt   <= '0;
         r_phase <= 1'b1;
      end else if (w_wrap) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else if (w_adv) begin
         r_cnt   <= r_cnt + CW'(1);
      end
   end

   assign o_phase  = r_phase;
   assign o_toggle = w_wrap;

endmodule : tick_phase_gen

// File: rtl/countdown_expiry_alarm.sv
// ---------------------------------------------------------------------------
// countdown_expiry_alarm
//   Watches an N-digit BCD countdown. Once the detector is armed by a running,
//   nonzero count, it reaches expiry when every digit reads 0. At expiry it
//   latches a stop to the counter and blinks the LED bank. After ALARM_TICKS
//   ticks it holds the bank steady-on. Both continue until ack.
//   ALARM_TICKS = 0 keeps the bank blinking until ack.
//   Ports:
//     clk    in     clock
//     reset  in     synchronous active-high reset
//     bus    slave  tick, run_en, digits, ack (in);
//                   stop, all_leds, alarm_active (out). All outputs are
//                   registered and have no combinational path from inputs.
// ---------------------------------------------------------------------------
module countdown_expiry_alarm
   import timer_pkg::*;
#(
   parameter int NUM_DIGITS  = 2,
   parameter int LED_WIDTH   = 12,
   parameter int BLINK_DIV   = 1,
   parameter int ALARM_TICKS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   countdown_expiry_alarm_if.slave  bus
);

   localparam int ACW_RAW = $clog2(ALARM_TICKS + 1);
   localparam int ACW     = (ACW_RAW < 1) ? 1 : ACW_RAW;
   localparam logic [ACW-1:0] ALARM_LAST =
      ACW'((ALARM_TICKS > 0) ? ALARM_TICKS - 1 : 0);

   localparam logic [LED_WIDTH-1:0] LEDS_ON  = LED_ALL_ON[LED_WIDTH-1:0];
   localparam logic [LED_WIDTH-1:0] LEDS_OFF = LED_ALL_OFF[LED_WIDTH-1:0];

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ACW-1:0]       r_alarm_cnt;
   logic                 r_stop;
   logic                 r_alarm_active;
   logic [LED_WIDTH-1:0] r_all_leds;

   logic                 w_zero;
   logic                 w_in_alarm;
   logic                 w_clear;
   logic                 w_alarm_done;
   logic                 w_phase;
   logic                 w_toggle;
   logic                 w_alarm_nxt;
   logic [LED_WIDTH-1:0] w_leds_nxt;

   // Expiry detect. A digit above 9 is nonzero, so corrupted BCD never
   // reads as zero.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path
      // through the block can leave it unassigned and infer a latch.
      w_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bus.digits[i*BCD_W +: BCD_W] != '0) w_zero = 1'b0;
      end
   end

   assign w_in_alarm = (r_state == ST_ALARM);
   // Counters sit cleared outside the alarm states. Every alarm therefore
   // starts with the LEDs on and a full ALARM_TICKS budget.
   assign w_clear    = (r_state == ST_IDLE) || (r_state == ST_ARMED);

   tick_phase_gen #(
      .DIV (BLINK_DIV)
   ) u_phase (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_clear),
      .i_tick   (bus.tick),
      .i_enable (w_in_alarm),
      .o_phase  (w_phase),
      .o_toggle (w_toggle)
   );

   assign w_alarm_done = (ALARM_TICKS != 0) && w_in_alarm && bus.tick &&
                         (r_alarm_cnt == ALARM_LAST);

   always_ff @(posedge clk) begin
      if (reset || w_clear) begin
         r_alarm_cnt <= '0;
      end else if (w_in_alarm && bus.tick && (ALARM_TICKS != 0)) begin
         r_alarm_cnt <= r_alarm_cnt + ACW'(1);
      end
   end

   // Next-state logic. ack takes priority over the tick-driven move to
   // STEADY. A zero count in ARMED takes priority over run_en dropping.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:   if (bus.run_en && !w_zero) w_state_nxt = ST_ARMED;
         ST_ARMED:  if (w_zero)                w_state_nxt = ST_ALARM;
                    else if (!bus.run_en)      w_state_nxt = ST_IDLE;
         ST_ALARM:  if (bus.ack)               w_state_nxt = ST_IDLE;
                    else if (w_alarm_done)     w_state_nxt = ST_STEADY;
         ST_STEADY: if (bus.ack)               w_state_nxt = ST_IDLE;
         default:                              w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state. They therefore change on
   // the same edge as the state register. w_phase ^ w_toggle is the phase
   // the blink generator holds after this edge.
   always_comb begin
      w_alarm_nxt = (w_state_nxt == ST_ALARM) || (w_state_nxt == ST_STEADY);
      w_leds_nxt  = LEDS_OFF;
      if (w_state_nxt == ST_STEADY) begin
         w_leds_nxt = LEDS_ON;
      end else if (w_state_nxt == ST_ALARM) begin
         w_leds_nxt = (w_phase ^ w_toggle) ? LEDS_ON : LEDS_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_stop         <= 1'b0;
         r_alarm_active <= 1'b0;
         r_all_leds     <= LEDS_OFF;
      end else begin
         r_state        <= w_state_nxt;
         r_stop         <= w_alarm_nxt;
         r_alarm_active <= w_alarm_nxt;
         r_all_leds     <= w_leds_nxt;
      end
   end

   assign bus.stop         = r_stop;
   assign bus.alarm_active = r_alarm_active;
   assign bus.all_leds     = r_all_leds;

endmodule : countdown_expiry_alarm

// File: tb/tb_countdown_expiry_alarm.sv
// ---------------------------------------------------------------------------
// tb_countdown_expiry_alarm
//   dut8 : BLINK_DIV=2, ALARM_TICKS=8   (table-driven main sequence)
//   dut0 : BLINK_DIV=2, ALARM_TICKS=0   (blink-forever sequence)
//   Each step drives the inputs and pushes the outputs expected after the next
//   rising edge onto a scoreboard queue. After the edge it pops the queue and
//   compares.
// ---------------------------------------------------------------------------
module tb_countdown_expiry_alarm;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   countdown_expiry_alarm_if #(.NUM_DIGITS(2), .LED_WIDTH(12)) if8 ();
   countdown_expiry_alarm_if #(.NUM_DIGITS(2), .LED_WIDTH(12)) if0 ();

   countdown_expiry_alarm #(
      .NUM_DIGITS(2), .LED_WIDTH(12), .BLINK_DIV(2), .ALARM_TICKS(8)
   ) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (if8)
   );

   countdown_expiry_alarm #(
      .NUM_DIGITS(2), .LED_WIDTH(12), .BLINK_DIV(2), .ALARM_TICKS(0)
   ) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );

   typedef struct {
      logic        rst;
      logic        tick;
      logic        run_en;
      logic [7:0]  digits;
      logic        ack;
      logic        stop;
      logic [11:0] leds;
      logic        active;
      string       tag;
   } vec_t;

   typedef struct {
      logic        stop;
      logic [11:0] leds;
      logic        active;
      string       tag;
   } exp_t;

   localparam logic [11:0] ON  = 12'hFFF;
   localparam logic [11:0] OFF = 12'h000;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic vec_t mk(input logic rst, input logic tick,
                               input logic run_en, input logic [7:0] digits,
                               input logic ack, input logic stop,
                               input logic [11:0] leds, input logic active,
                               input string tag);
      vec_t v;
      v.rst = rst; v.tick = tick; v.run_en = run_en; v.digits = digits;
      v.ack = ack; v.stop = stop; v.leds = leds; v.active = active;
      v.tag = tag;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp,
                  $time);
      end
   endtask

   // Drive one cycle on the selected DUT (0 = dut8, 1 = dut0), then score it.
   task automatic apply(input int sel, input vec_t v);
      exp_t e;
      reset = v.rst;
      if (sel == 0) begin
         if8.tick = v.tick; if8.run_en = v.run_en;
         if8.digits = v.digits; if8.ack = v.ack;
      end else begin
         if0.tick = v.tick; if0.run_en = v.run_en;
         if0.digits = v.digits; if0.ack = v.ack;
      end
      e.stop = v.stop; e.leds = v.leds; e.active = v.active; e.tag = v.tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({v.tag, ".scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         if (sel == 0) begin
            check({e.tag, ".stop"},   32'(if8.stop),         32'(e.stop));
            check({e.tag, ".leds"},   32'(if8.all_leds),     32'(e.leds));
            check({e.tag, ".active"}, 32'(if8.alarm_active), 32'(e.active));
         end else begin
            check({e.tag, ".stop"},   32'(if0.stop),         32'(e.stop));
            check({e.tag, ".leds"},   32'(if0.all_leds),     32'(e.leds));
            check({e.tag, ".active"}, 32'(if0.alarm_active), 32'(e.active));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         m_cnt;
      logic       m_phase;
      logic [11:0] pat;

      if8.tick = 0; if8.run_en = 0; if8.digits = 8'h00; if8.ack = 0;
      if0.tick = 0; if0.run_en = 0; if0.digits = 8'h00; if0.ack = 0;

      // Columns: rst tick run digits ack | stop leds active
      // Power-up: a zero count never arms.
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1, 0, 1, 8'h00, 0, 0, OFF, 0, "pwr_reset"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, OFF, 0, "pwr_idle0"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 0, OFF, 0, "pwr_idle1"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, OFF, 0, "pwr_idle2"));
      // Normal expiry 03 -> 00. The alarm is visible one clk after 00.
      vecs.push_back(mk(0, 0, 1, 8'h03, 0, 0, OFF, 0, "exp_arm"));
      vecs.push_back(mk(0, 1, 1, 8'h03, 0, 0, OFF, 0, "exp_03"));
      vecs.push_back(mk(0, 0, 1, 8'h02, 0, 0, OFF, 0, "exp_02a"));
      vecs.push_back(mk(0, 1, 1, 8'h02, 0, 0, OFF, 0, "exp_02b"));
      vecs.push_back(mk(0, 0, 1, 8'h01, 0, 0, OFF, 0, "exp_01a"));
      vecs.push_back(mk(0, 1, 1, 8'h01, 0, 0, OFF, 0, "exp_01b"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, ON,  1, "exp_fire"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, ON,  1, "exp_t1"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, ON,  1, "exp_t1_hold"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, OFF, 1, "exp_t2"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, OFF, 1, "exp_t3"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, ON,  1, "exp_t4"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, ON,  1, "exp_t5"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, OFF, 1, "exp_t6"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, OFF, 1, "exp_t7"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, ON,  1, "exp_t8_steady"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, ON,  1, "steady_t9"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, ON,  1, "steady_t10"));
      vecs.push_back(mk(0, 0, 1, 8'h55, 0, 1, ON,  1, "steady_digits"));
      vecs.push_back(mk(0, 0, 1, 8'h55, 1, 0, OFF, 0, "steady_ack"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, OFF, 0, "post_ack_idle"));
      // Ack on the same clk as the 8th tick beats the move to STEADY.
      vecs.push_back(mk(0, 0, 1, 8'h02, 0, 0, OFF, 0, "ackp_arm"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, ON,  1, "ackp_fire"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, ON,  1, "ackp_t1"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, OFF, 1, "ackp_t2"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, OFF, 1, "ackp_t3"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, ON,  1, "ackp_t4"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, ON,  1, "ackp_t5"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, OFF, 1, "ackp_t6"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, OFF, 1, "ackp_t7"));
      vecs.push_back(mk(0, 1, 1, 8'h00, 1, 0, OFF, 0, "ackp_t8_ack"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, OFF, 0, "ackp_idle"));
      // Disarm: run_en drops before the count reaches zero.
      vecs.push_back(mk(0, 0, 1, 8'h15, 0, 0, OFF, 0, "dis_arm"));
      vecs.push_back(mk(0, 0, 0, 8'h15, 0, 0, OFF, 0, "dis_drop"));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, OFF, 0, "dis_zero"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, OFF, 0, "dis_zero_run"));
      // Invalid BCD digits count as nonzero.
      vecs.push_back(mk(0, 0, 1, 8'h0A, 0, 0, OFF, 0, "bcd_arm_0A"));
      vecs.push_back(mk(0, 1, 1, 8'h0A, 0, 0, OFF, 0, "bcd_hold_0A"));
      vecs.push_back(mk(0, 0, 1, 8'hA0, 0, 0, OFF, 0, "bcd_hold_A0"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, ON,  1, "bcd_fire"));
      // Synchronous reset in ALARM clears everything on that edge.
      vecs.push_back(mk(0, 1, 1, 8'h00, 0, 1, ON,  1, "rst_t1"));
      vecs.push_back(mk(1, 0, 1, 8'h00, 0, 0, OFF, 0, "rst_mid"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, OFF, 0, "rst_after"));
      // ARMED ignores ack, and zero beats run_en=0.
      vecs.push_back(mk(0, 0, 1, 8'h05, 0, 0, OFF, 0, "arm_ack_arm"));
      vecs.push_back(mk(0, 0, 1, 8'h05, 1, 0, OFF, 0, "arm_ack_ign"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, ON,  1, "arm_ack_fire"));
      vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, OFF, 0, "arm_ack_clr"));
      vecs.push_back(mk(0, 0, 1, 8'h07, 0, 0, OFF, 0, "prio_arm"));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, ON,  1, "prio_zero_wins"));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, OFF, 0, "prio_ack"));

      for (int i = 0; i < vecs.size(); i++) apply(0, vecs[i]);

      // ALARM_TICKS=0: 40 ticks of blinking with no STEADY, then ack.
      apply(1, mk(1, 0, 0, 8'h00, 0, 0, OFF, 0, "t0_reset"));
      apply(1, mk(0, 0, 1, 8'h01, 0, 0, OFF, 0, "t0_arm"));
      apply(1, mk(0, 0, 1, 8'h00, 0, 1, ON,  1, "t0_fire"));
      m_cnt   = 0;
      m_phase = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (m_cnt == 1) begin
            m_cnt   = 0;
            m_phase = ~m_phase;
         end else begin
            m_cnt++;
         end
         pat = m_phase ? ON : OFF;
         apply(1, mk(0, 1, 1, 8'h00, 0, 1, pat, 1, "t0_tick"));
         apply(1, mk(0, 0, 1, 8'h00, 0, 1, pat, 1, "t0_gap"));
      end
      apply(1, mk(0, 0, 1, 8'h00, 1, 0, OFF, 0, "t0_ack"));
      apply(1, mk(0, 0, 1, 8'h00, 0, 0, OFF, 0, "t0_idle"));

      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_countdown_expiry_alarm
